// File: rtl/csa_serial_sub.sv
// csa_serial_sub: multi-cycle subtractor, DIFF = A - B, one 4-bit nibble per clock.
// Each nibble is A_k + ~B_k + carry, and the running carry is kept in a flop.
// The nibble adder is carry-select: the cin=0 and cin=1 ripple paths are both
// computed, and the carry flop picks one. A start/busy/done handshake frames each op.
module csa_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic [3:0] a_nib, b_nib;
    logic [4:0] path0, path1, nib_sel;
    logic [3:0] nib_sum;
    logic       nib_cout;
    logic       last_nib;

    // Plain 4-bit ripple adder; returns {carry_out, sum}.
    function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
        logic       c;
        logic [3:0] s;
        c = cin;
        s = '0;
        for (int j = 0; j < 4; j++) begin
            s[j] = x[j] ^ y[j] ^ c;
            c    = (x[j] & y[j]) | (c & (x[j] ^ y[j]));
        end
        return {c, s};
    endfunction

    // Pick the operand nibbles for the current step, then form both carry-select paths.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == CW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
        path0    = ripple4(a_nib, ~b_nib, 1'b0);
        path1    = ripple4(a_nib, ~b_nib, 1'b1);
        nib_sel  = carry_q ? path1 : path0;
        nib_sum  = nib_sel[3:0];
        nib_cout = nib_sel[4];
        last_nib = (idx_q == CW'(N - 1));
    end

    // State register and datapath flops; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next state: DONE may accept a new start directly, which gives back-to-back operation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last_nib ? DONE : RUN;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values. Capture happens on an accepted start; one nibble is written per RUN edge.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        if (state_q != RUN && start) begin
            a_d     = a;
            b_d     = b;
            carry_d = 1'b1;
            idx_d   = '0;
            diff_d  = '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < N; i++) begin
                if (idx_q == CW'(i)) begin
                    diff_d[4*i +: 4] = nib_sum;
                end
            end
            carry_d = nib_cout;
            idx_d   = idx_q + CW'(1);
            if (last_nib) begin
                borrow_d = ~nib_cout;
                ovf_d    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ nib_sum[3]);
            end
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        busy   = (state_q == RUN);
        done   = (state_q == DONE);
        diff   = diff_q;
        borrow = borrow_q;
        ovf    = ovf_q;
    end

endmodule
